// File: rtl/decode_queue.sv
// Decoded-instruction queue between the static decoder and dispatch/rename.
// Optional macro DECODE_QUEUE_BYPASS_EN: empty queue forwards input to output in the same cycle.

package C;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } si_t;
endpackage

module decode_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  C::si_t                   in_si_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output C::si_t                   out_si_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  C::si_t      r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic   w_empty;
  logic   w_full;
  logic   w_push;
  logic   w_pop;
  C::si_t w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Ready is independent of out_ready_i: a full queue refuses even on a same-cycle pop.
  assign in_ready_o = !w_full && !flush_i;

`ifdef DECODE_QUEUE_BYPASS_EN
  logic w_bypass;

  assign w_bypass    = w_empty && !flush_i;
  assign out_valid_o = w_bypass ? in_valid_i : (!w_empty && !flush_i);
  assign w_head      = w_bypass ? in_si_i : r_mem[r_rd_ptr[AW-1:0]];
  // A record consumed straight through never lands in storage.
  assign w_push      = in_valid_i && in_ready_o && !(w_bypass && out_ready_i);
`else
  assign out_valid_o = !w_empty && !flush_i;
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push      = in_valid_i && in_ready_o;
`endif

  assign w_pop    = out_valid_o && out_ready_i && !w_empty;
  assign out_si_o = out_valid_o ? w_head : '0;
  assign count_o  = r_wr_ptr - r_rd_ptr;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage has no reset; the pointers alone define which slots are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_si_i;
  end

endmodule

// File: doc/decode_queue.md
# decode_queue

Decoded-instruction queue between the static decoder and the dispatch/rename stage. It buffers `C::si_t` records produced by the decoder each cycle, decouples decoder throughput from dispatch back-pressure with a valid/ready handshake on both sides, and discards all buffered records on a pipeline flush. Illegal instructions (`si.valid == 0`) are queued like any other record; dispatch raises the exception.

## Interface

Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.

Ports:
- `clk_i` input 1: clock.
- `rstn_i` input 1: reset. One clock; reset is asynchronous and active-low.
- `flush_i` input 1: discard all entries; has priority over every other input.
- `in_valid_i` input 1: decoder presents a record.
- `in_ready_o` output 1: queue accepts the record this cycle.
- `in_si_i` input `C::si_t`: decoded record from the decoder.
- `out_valid_o` output 1: head record available to dispatch.
- `out_ready_i` input 1: dispatch consumes the head this cycle.
- `out_si_o` output `C::si_t`: head record.
- `count_o` output `$clog2(DEPTH)+1`: number of stored entries.

## Operation

- Storage: circular buffer of `DEPTH` `C::si_t` slots. Write and read pointers are `$clog2(DEPTH)+1` bits; the MSB is a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ. `count_o` is `wr_ptr - rd_ptr` modulo `2*DEPTH`.
- Push: a push happens when `in_valid_i && in_ready_o`. The record is written at `wr_ptr` and `wr_ptr` increments, wrapping naturally.
- Pop: a pop happens when `out_valid_o && out_ready_i`. `rd_ptr` increments.
- Ready: `in_ready_o = !full && !flush_i`. It never depends on `out_ready_i`, so a full queue refuses a push even when a pop happens in the same cycle.
- Valid: `out_valid_o = !empty && !flush_i`.
- Head record: `out_si_o` is the record at the head slot. When `out_valid_o` is 0, `out_si_o` is driven to all zeros.
- Simultaneous push and pop on a non-full, non-empty queue: both happen and the count is unchanged.
- Flush: when `flush_i` is 1, there is no push and no pop. Both pointers reset to 0 at the next edge, so the queue is empty the following cycle. Storage contents are not cleared.
- Reset (asynchronous, at any time including mid-transfer):
  - Pointers go to 0 and `count_o` goes to 0.
  - `out_valid_o` goes to 0 and `out_si_o` goes to 0.
  - `in_ready_o` goes to 1 (while `flush_i` is 0).
- No FSM. State is the two pointers and the storage only.

## Timing

- Latency without bypass: a record pushed at edge N is visible on `out_*` in the cycle after edge N, so there is 1 cycle of latency.
- Throughput: one push and one pop per cycle sustained.
- All outputs are combinational from the registers, plus `flush_i`. In bypass mode they also depend on `in_valid_i`/`in_si_i`.
- `in_ready_o` has no combinational path from `out_ready_i`.
- Flush takes effect in the same cycle: `out_valid_o` and `in_ready_o` are 0 while `flush_i` is 1.

## Configuration

- `DECODE_QUEUE_BYPASS_EN`
  - Defined, when the queue is empty and `flush_i` is 0:
    - `out_valid_o = in_valid_i` and `out_si_o = in_si_i` in the same cycle (0 cycles of latency).
    - If `out_ready_i` is also 1, the record is consumed directly and is not written into storage.
    - If `out_ready_i` is 0, the record is written normally.
  - Undefined: no combinational path from the input side to the output side; minimum latency is 1 cycle.

## Test plan

- Fill then drain, `DEPTH`=4, `out_ready_i`=0:
  - Push records with `pc` 0x100, 0x104, 0x108, 0x10C → `count_o`=4 and `in_ready_o`=0 after the 4th.
  - A 5th push attempt is refused.
  - Then `out_ready_i`=1 → the four records are popped in order 0x100..0x10C and `count_o` returns to 0.
- Wrap-around: 10 back-to-back push+pop cycles with `out_ready_i`=1 → each record appears the next cycle (no bypass), in order, with no loss. Pointers wrap past index 3, and `count_o` stays at 1 in steady state.
- Full with simultaneous pop: queue full, `in_valid_i`=1, `out_ready_i`=1 → one pop, no push, `count_o`=3 at the next edge.
- Flush mid-stream: 3 entries stored, assert `flush_i` for 1 cycle along with `in_valid_i` → `out_valid_o`=0 and `in_ready_o`=0 that cycle; `count_o`=0 the next cycle. The flushed-cycle record is not stored.
- Asynchronous reset: drop `rstn_i` mid-cycle with 2 entries stored → `out_valid_o`=0, `count_o`=0 and `out_si_o`=0 immediately, before the next clock edge. After release, `in_ready_o`=1.
- Bypass, only with `DECODE_QUEUE_BYPASS_EN`: empty queue, `in_valid_i`=1 with `pc`=0x200, `out_ready_i`=1 → `out_valid_o`=1 with `pc` 0x200 in the same cycle, and `count_o` stays 0.
